// File: rtl/reg_file_if.sv
// Issuer/ROB-facing bundle of the register file: operand reads, rename writes, commits and flush.
// The register file takes the slave side; the issuer/ROB side (or a bench) takes master.
interface reg_file_if #(
  parameter int XLEN         = 32,
  parameter int ROB_ID_WIDTH = 4
);
  logic [4:0]              rs1_from_issuer;
  logic [4:0]              rs2_from_issuer;
  logic [XLEN-1:0]         vj_to_issuer;
  logic [ROB_ID_WIDTH-1:0] qj_to_issuer;
  logic [XLEN-1:0]         vk_to_issuer;
  logic [ROB_ID_WIDTH-1:0] qk_to_issuer;
  logic                    valid_from_issuer;
  logic [4:0]              rd_from_issuer;
  logic [ROB_ID_WIDTH-1:0] dest_from_issuer;
  logic [ROB_ID_WIDTH-1:0] dest_from_rob;
  logic [4:0]              rd_from_rob;
  logic [XLEN-1:0]         value_from_rob;
  logic                    reset_from_rob_bus;

  modport slave (
    input  rs1_from_issuer, rs2_from_issuer, valid_from_issuer, rd_from_issuer, dest_from_issuer,
    input  dest_from_rob, rd_from_rob, value_from_rob, reset_from_rob_bus,
    output vj_to_issuer, qj_to_issuer, vk_to_issuer, qk_to_issuer
  );

  modport master (
    output rs1_from_issuer, rs2_from_issuer, valid_from_issuer, rd_from_issuer, dest_from_issuer,
    output dest_from_rob, rd_from_rob, value_from_rob, reset_from_rob_bus,
    input  vj_to_issuer, qj_to_issuer, vk_to_issuer, qk_to_issuer
  );
endinterface

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags; combinational operand read with
// commit bypass, single-cycle rename/commit/flush update; rdy=0 freezes all state.
module reg_file #(
  parameter int REG_NUM      = 32,
  parameter int XLEN         = 32,
  parameter int ROB_ID_WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  reg_file_if.slave  bus
);

  logic [XLEN-1:0]         value_q [REG_NUM-1:1];
  logic [XLEN-1:0]         value_d [REG_NUM-1:1];
  logic [ROB_ID_WIDTH-1:0] tag_q   [REG_NUM-1:1];
  logic [ROB_ID_WIDTH-1:0] tag_d   [REG_NUM-1:1];

  logic commit;
  logic rename;

  assign commit = (bus.dest_from_rob != '0) && (bus.rd_from_rob != 5'd0);
  assign rename = bus.valid_from_issuer && (bus.rd_from_issuer != 5'd0);

  // Operand lookup; a matching commit this cycle is forwarded so the issuer never waits on it.
  function automatic logic [XLEN+ROB_ID_WIDTH-1:0] read_op(input logic [4:0] rs);
    logic [XLEN-1:0]         v;
    logic [ROB_ID_WIDTH-1:0] q;
    v = '0;
    q = '0;
    if (rs != 5'd0) begin
      if (tag_q[rs] == '0) begin
        v = value_q[rs];
      end else if (commit && (bus.rd_from_rob == rs) && (tag_q[rs] == bus.dest_from_rob)) begin
        v = bus.value_from_rob;
      end else begin
        q = tag_q[rs];
      end
    end
    return {v, q};
  endfunction

  always_comb begin
    {bus.vj_to_issuer, bus.qj_to_issuer} = read_op(bus.rs1_from_issuer);
    {bus.vk_to_issuer, bus.qk_to_issuer} = read_op(bus.rs2_from_issuer);
  end

  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    if (commit) begin
      value_d[bus.rd_from_rob] = bus.value_from_rob;
      // Only the producer that owns the mapping may release it; a newer writer keeps its tag.
      if (tag_q[bus.rd_from_rob] == bus.dest_from_rob) begin
        tag_d[bus.rd_from_rob] = '0;
      end
    end
    if (bus.reset_from_rob_bus) begin
      for (int i = 1; i < REG_NUM; i++) begin
        tag_d[i] = '0;
      end
    end else if (rename) begin
      tag_d[bus.rd_from_issuer] = bus.dest_from_issuer;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < REG_NUM; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (rdy) begin
      value_q <= value_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed scenarios plus randomized traffic against an array-based model.
module tb_reg_file;
  localparam int XLEN = 32;
  localparam int RW   = 4;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [XLEN-1:0] m_val [32];
  logic [RW-1:0]   m_tag [32];

  reg_file_if #(.XLEN(XLEN), .ROB_ID_WIDTH(RW)) bus ();

  reg_file #(.REG_NUM(32), .XLEN(XLEN), .ROB_ID_WIDTH(RW)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.rs1_from_issuer    = 5'd0;
    bus.rs2_from_issuer    = 5'd0;
    bus.valid_from_issuer  = 1'b0;
    bus.rd_from_issuer     = 5'd0;
    bus.dest_from_issuer   = '0;
    bus.dest_from_rob      = '0;
    bus.rd_from_rob        = 5'd0;
    bus.value_from_rob     = '0;
    bus.reset_from_rob_bus = 1'b0;
    rst = 1'b0;
    rdy = 1'b1;
  endtask

  // Expected operand for a source register given the model state and the commit on the bus.
  task automatic model_read(input logic [4:0] rs, output logic [31:0] v, output logic [31:0] q);
    v = 0;
    q = 0;
    if (rs == 0) return;
    if (m_tag[rs] == 0) v = m_val[rs];
    else if (bus.dest_from_rob != 0 && bus.rd_from_rob == rs && bus.dest_from_rob == m_tag[rs])
      v = bus.value_from_rob;
    else q = 32'(m_tag[rs]);
  endtask

  task automatic check_reads();
    logic [31:0] v, q;
    #1;
    model_read(bus.rs1_from_issuer, v, q);
    check("vj", bus.vj_to_issuer, v);
    check("qj", 32'(bus.qj_to_issuer), q);
    model_read(bus.rs2_from_issuer, v, q);
    check("vk", bus.vk_to_issuer, v);
    check("qk", 32'(bus.qk_to_issuer), q);
  endtask

  // Advance one clock and apply the architectural effect of the sampled inputs to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 0;
        m_tag[i] = 0;
      end
    end else if (rdy) begin
      if (bus.dest_from_rob != 0 && bus.rd_from_rob != 0) begin
        m_val[bus.rd_from_rob] = bus.value_from_rob;
        if (m_tag[bus.rd_from_rob] == bus.dest_from_rob) m_tag[bus.rd_from_rob] = 0;
      end
      if (bus.reset_from_rob_bus) begin
        for (int i = 0; i < 32; i++) m_tag[i] = 0;
      end else if (bus.valid_from_issuer && bus.rd_from_issuer != 0) begin
        m_tag[bus.rd_from_issuer] = bus.dest_from_issuer;
      end
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] rd, input logic [RW-1:0] d);
    bus.valid_from_issuer = 1'b1;
    bus.rd_from_issuer    = rd;
    bus.dest_from_issuer  = d;
  endtask

  task automatic commit(input logic [RW-1:0] d, input logic [4:0] rd, input logic [31:0] v);
    bus.dest_from_rob  = d;
    bus.rd_from_rob    = rd;
    bus.value_from_rob = v;
  endtask

  task automatic rd2(input logic [4:0] a, input logic [4:0] b);
    bus.rs1_from_issuer = a;
    bus.rs2_from_issuer = b;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 'x;
      m_tag[i] = 'x;
    end
    idle();
    @(negedge clk);
    rst = 1'b1;
    tick();
    idle();

    rd2(5, 0);
    check("rst_vj", bus.vj_to_issuer, 0);
    check("rst_qj", 32'(bus.qj_to_issuer), 0);
    check("rst_vk", bus.vk_to_issuer, 0);
    check("rst_qk", 32'(bus.qk_to_issuer), 0);

    issue(3, 2); tick(); idle();
    rd2(3, 0);
    check("ren_qj", 32'(bus.qj_to_issuer), 2);
    commit(2, 3, 32'h1234); rd2(3, 0);
    check("byp_vj", bus.vj_to_issuer, 32'h1234);
    check("byp_qj", 32'(bus.qj_to_issuer), 0);
    tick(); idle(); rd2(3, 0);
    check("cmt_vj", bus.vj_to_issuer, 32'h1234);
    check("cmt_qj", 32'(bus.qj_to_issuer), 0);

    issue(4, 1); tick(); idle();
    issue(4, 5); tick(); idle();
    commit(1, 4, 7); rd2(4, 0);
    check("old_cmt_qj", 32'(bus.qj_to_issuer), 5);
    tick(); idle(); rd2(4, 0);
    check("newer_tag_kept", 32'(bus.qj_to_issuer), 5);

    commit(5, 4, 9); issue(4, 6); rd2(4, 0);
    check("same_cyc_byp", bus.vj_to_issuer, 9);
    tick(); idle(); rd2(4, 0);
    check("rename_wins", 32'(bus.qj_to_issuer), 6);

    issue(1, 3); tick(); idle();
    issue(2, 4); tick(); idle();
    issue(7, 7); tick(); idle();
    bus.reset_from_rob_bus = 1'b1; commit(3, 1, 32'h80); issue(9, 8);
    tick(); idle();
    rd2(1, 9);
    check("flush_v1", bus.vj_to_issuer, 32'h80);
    check("flush_q1", 32'(bus.qj_to_issuer), 0);
    check("flush_q9", 32'(bus.qk_to_issuer), 0);
    rd2(7, 2);
    check("flush_q7", 32'(bus.qj_to_issuer), 0);
    check("flush_q2", 32'(bus.qk_to_issuer), 0);
    rd2(4, 0);
    check("flush_v4", bus.vj_to_issuer, 9);

    rdy = 1'b0; issue(6, 2); commit(3, 6, 32'h55); tick(); idle();
    rd2(6, 0);
    check("hold_v6", bus.vj_to_issuer, 0);
    check("hold_q6", 32'(bus.qj_to_issuer), 0);
    issue(0, 3); commit(3, 0, 32'hdead); tick(); idle();
    rd2(0, 0);
    check("x0_v", bus.vj_to_issuer, 0);
    check("x0_q", 32'(bus.qj_to_issuer), 0);

    issue(5, 9); tick(); idle();
    rst = 1'b1; rdy = 1'b0; tick(); idle();
    rd2(5, 1);
    check("rst_over_rdy_q", 32'(bus.qj_to_issuer), 0);
    check("rst_over_rdy_v", bus.vk_to_issuer, 0);

    // Small register window keeps renames, commits and reads colliding often.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] r;
      idle();
      rst = ($urandom_range(63) == 0);
      rdy = ($urandom_range(7) != 0);
      bus.reset_from_rob_bus = ($urandom_range(15) == 0);
      bus.rs1_from_issuer = 5'($urandom_range(7));
      bus.rs2_from_issuer = 5'($urandom_range(7));
      bus.valid_from_issuer = $urandom_range(1);
      bus.rd_from_issuer = 5'($urandom_range(7));
      bus.dest_from_issuer = RW'($urandom_range(15, 1));
      r = 5'($urandom_range(7));
      bus.rd_from_rob = r;
      bus.dest_from_rob = ($urandom_range(2) == 0) ? RW'($urandom_range(15))
                                                   : m_tag[r];
      if ($urandom_range(3) == 0) bus.rd_from_rob = bus.rs1_from_issuer;
      bus.value_from_rob = $urandom;
      check_reads();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with per-register rename tags.
- Sits between the issuer and the reorder buffer.
  - Supplies operand values or producer ROB ids (qj/qk) to the issuer.
  - Records the ROB id of the newest in-flight writer of each register at issue time.
  - Retires values committed by the ROB.
- A ROB-bus flush discards all rename tags; architectural values are kept.

Parameters:
- REG_NUM, 32, number of architectural registers; x0 hardwired to 0.
- XLEN, 32, register data width.
- ROB_ID_WIDTH, 4, width of ROB ids; valid ids are 1..15; 0 means "no producer / none".

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- rdy  input  1  global ready; when low, all state holds.
- rs1_from_issuer  input  5  source register 1 index.
- rs2_from_issuer  input  5  source register 2 index.
- vj_to_issuer  output  XLEN  rs1 value; valid when qj_to_issuer==0.
- qj_to_issuer  output  ROB_ID_WIDTH  rs1 producer ROB id; 0 = value ready.
- vk_to_issuer  output  XLEN  rs2 value; valid when qk_to_issuer==0.
- qk_to_issuer  output  ROB_ID_WIDTH  rs2 producer ROB id; 0 = value ready.
- valid_from_issuer  input  1  instruction issued this cycle.
- rd_from_issuer  input  5  destination register of the issued instruction; 0 = none.
- dest_from_issuer  input  ROB_ID_WIDTH  ROB id allocated to the issued instruction.
- dest_from_rob  input  ROB_ID_WIDTH  committing ROB id; 0 = no commit.
- rd_from_rob  input  5  committing destination register.
- value_from_rob  input  XLEN  committed value.
- reset_from_rob_bus  input  1  misprediction flush.

Behaviour:
- State:
  - value[1..31], XLEN bits each.
  - tag[1..31], ROB_ID_WIDTH bits each.
  - Index 0 is not stored: reads of x0 return v=0, q=0.
- Reset (rst=1 at posedge): all value=0, all tag=0. rst has priority over every other input, including rdy=0.
- Read path is combinational, zero latency. For rsX != 0:
  - If tag[rsX]==0: v=value[rsX], q=0.
  - Else if dest_from_rob!=0, rd_from_rob==rsX and tag[rsX]==dest_from_rob (commit bypass): v=value_from_rob, q=0.
  - Else: v=0, q=tag[rsX].
  - Reads never observe a same-cycle rename, so rd==rs in one instruction reads the old mapping (e.g. addi x1,x1,1).
  - Reads are not gated by rdy or reset_from_rob_bus.
- Commit, at posedge when rdy && !rst && dest_from_rob!=0 && rd_from_rob!=0:
  - value[rd_from_rob] <= value_from_rob unconditionally (in-order commit).
  - tag[rd_from_rob] <= 0 only if tag[rd_from_rob]==dest_from_rob.
  - A newer writer's tag is never cleared.
- Rename, at posedge when rdy && !rst && valid_from_issuer && rd_from_issuer!=0 && !reset_from_rob_bus:
  - tag[rd_from_issuer] <= dest_from_issuer.
- Same-cycle commit and rename on the same register: the rename tag wins; the value is still written.
- Flush, at posedge when rdy && !rst && reset_from_rob_bus:
  - All tags <= 0; the rename is dropped.
  - A commit presented in the same cycle still writes its value; this covers the link value of a mispredicted jalr retiring with the flush.
- rdy=0: no value or tag updates; outputs still track inputs combinationally.
- Writes to x0, by rename or commit, are ignored.
- Registers with tag 0 must never produce a nonzero q.

Test Plan:
- Reset then read x5, x0 -> vj=0, qj=0, vk=0, qk=0.
- Issue rd=3, dest=2; next cycle read rs1=3 -> qj=2. Commit dest=2, rd=3, value=0x1234 -> same-cycle read gives vj=0x1234, qj=0; next cycle tag[3]=0 and value=0x1234.
- Issue rd=4 dest=1, then rd=4 dest=5; commit dest=1 rd=4 value=7 -> value[4]=7, qj for rs1=4 stays 5.
- Same cycle: commit dest=5 rd=4 value=9 and issue rd=4 dest=6 -> value[4]=9, tag[4]=6.
- Tags set on x1, x2, x7; reset_from_rob_bus=1 with commit dest=3 rd=1 value=0x80 and valid issue rd=9 -> all q=0, value[1]=0x80, tag[9]=0.
- rdy=0 with issue rd=6 and commit rd=6 -> no state change. Issue rd=0 dest=3 -> x0 reads v=0, q=0.
